bram_arbiter: RTL and testbench

Shares the single-port parity-protected instruction BRAM between N_REQ requesters, for example the host register path and the engine fetch ports. Each cycle the block grants at most one request by round-robin and registers it onto the BRAM port. It returns read data in order to the issuing requester, with per-byte parity checking. The block sits between the requesters and the `bram` instance, replacing direct combinational drive of the BRAM.

---
 rtl/bram_arbiter_pkg.sv | 28 ++
 rtl/bram_arbiter_rr.sv | 53 +++++
 rtl/bram_arbiter.sv | 132 +++++++++++++
 tb/tb_bram_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arbiter_pkg.sv
// Shared BRAM geometry, response tag type and the byte-parity encoder used by
// the instruction BRAM arbiter.
package bram_arbiter_pkg;

  localparam int BRAM_ADDR_WIDTH  = 11;
  localparam int BRAM_READ_WIDTH  = 18;
  localparam int BRAM_WRITE_WIDTH = 36;
  localparam int BRAM_WE_WIDTH    = 4;

  // Wide enough for up to 256 requesters; the arbiter zero-extends its index.
  localparam int TAG_ID_WIDTH = 8;

  typedef struct packed {
    logic                    valid;
    logic [TAG_ID_WIDTH-1:0] id;
  } resp_tag_t;

  // Each byte is stored as {parity, byte}, byte 0 in the low nine bits.
  function automatic logic [BRAM_WRITE_WIDTH-1:0] parity_encode32(input logic [31:0] data);
    logic [BRAM_WRITE_WIDTH-1:0] word;
    word = '0;
    for (int b = 0; b < 4; b++) begin
      word[b*9 +: 9] = {^data[b*8 +: 8], data[b*8 +: 8]};
    end
    return word;
  endfunction

endpackage

// File: rtl/bram_arbiter_rr.sv
// Round-robin arbiter: searches from ptr_i upward with wrap and returns the
// one-hot grant, its index and the pointer to use after this cycle.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  input  logic                 advance_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] grant_idx_o,
  output logic [$clog2(N)-1:0] ptr_next_o
);

  localparam int IW = $clog2(N);
  localparam int SW = IW + 1;

  logic          found;
  logic [SW-1:0] sum;
  logic [IW-1:0] cand;

  // One extra bit on the candidate sum lets the wrap work for any N.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    sum         = '0;
    cand        = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_i} + SW'(k);
      if (sum >= SW'(N)) begin
        sum = sum - SW'(N);
      end
      cand = sum[IW-1:0];
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        grant_idx_o   = cand;
      end
    end
  end

  always_comb begin
    ptr_next_o = ptr_i;
    if (advance_i && found) begin
      if (grant_idx_o == IW'(N - 1)) begin
        ptr_next_o = '0;
      end else begin
        ptr_next_o = grant_idx_o + IW'(1);
      end
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Shares the single-port parity-protected instruction BRAM between N_REQ
// requesters; registers one grant per cycle and returns reads in order.
module bram_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int ADDR_WIDTH  = BRAM_ADDR_WIDTH,
  parameter int READ_WIDTH  = BRAM_READ_WIDTH,
  parameter int WRITE_WIDTH = BRAM_WRITE_WIDTH,
  parameter int WE_WIDTH    = BRAM_WE_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ-1:0]            req_we,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*32-1:0]         req_wdata,
  output logic [N_REQ-1:0]            resp_valid,
  output logic [15:0]                 resp_data,
  output logic [1:0]                  resp_perr,
  output logic [15:0]                 perr_count,
  output logic [ADDR_WIDTH-1:0]       bram_addr,
  output logic [WRITE_WIDTH-1:0]      bram_in,
  output logic [WE_WIDTH-1:0]         bram_we,
  output logic                        bram_valid,
  input  logic [READ_WIDTH-1:0]       bram_out
);

  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    grant_idx;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic             handshake;
  logic             sel_we;

  logic [ADDR_WIDTH-1:0]  bram_addr_q, bram_addr_d;
  logic [WRITE_WIDTH-1:0] bram_in_q, bram_in_d;
  logic [WE_WIDTH-1:0]    bram_we_q, bram_we_d;
  logic                   bram_valid_q, bram_valid_d;

  resp_tag_t   tag1_q, tag1_d, tag2_q;
  logic [15:0] perr_count_q, perr_count_d;

  // A grant exists whenever anything is valid, so that alone is the handshake.
  assign handshake = reset && (|req_valid);
  assign req_ready = reset ? grant : '0;
  assign sel_we    = req_we[grant_idx];

  rr_arbiter #(
    .N(N_REQ)
  ) u_rr (
    .req_i      (req_valid),
    .ptr_i      (ptr_q),
    .advance_i  (handshake),
    .grant_o    (grant),
    .grant_idx_o(grant_idx),
    .ptr_next_o (ptr_d)
  );

  always_comb begin
    bram_addr_d  = bram_addr_q;
    bram_in_d    = bram_in_q;
    bram_we_d    = '0;
    bram_valid_d = 1'b0;
    tag1_d       = '0;
    if (handshake) begin
      bram_addr_d  = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
      bram_valid_d = 1'b1;
      if (sel_we) begin
        bram_we_d = '1;
        bram_in_d = WRITE_WIDTH'(parity_encode32(req_wdata[grant_idx*32 +: 32]));
      end else begin
        bram_in_d    = '0;
        tag1_d.valid = 1'b1;
        tag1_d.id    = TAG_ID_WIDTH'(grant_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q        <= '0;
      bram_addr_q  <= '0;
      bram_in_q    <= '0;
      bram_we_q    <= '0;
      bram_valid_q <= 1'b0;
      tag1_q       <= '0;
      tag2_q       <= '0;
      perr_count_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      bram_addr_q  <= bram_addr_d;
      bram_in_q    <= bram_in_d;
      bram_we_q    <= bram_we_d;
      bram_valid_q <= bram_valid_d;
      tag1_q       <= tag1_d;
      tag2_q       <= tag1_q;
      perr_count_q <= perr_count_d;
    end
  end

  assign bram_addr  = bram_addr_q;
  assign bram_in    = bram_in_q;
  assign bram_we    = bram_we_q;
  assign bram_valid = bram_valid_q;

  // Stage-2 tag lines up with the BRAM read data, one cycle after the port.
  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (tag2_q.valid && (tag2_q.id == TAG_ID_WIDTH'(i))) begin
        resp_valid[i] = 1'b1;
      end
    end
  end

  assign resp_data    = {bram_out[16:9], bram_out[7:0]};
  assign resp_perr[1] = ^bram_out[17:9];
  assign resp_perr[0] = ^bram_out[8:0];

  always_comb begin
    perr_count_d = perr_count_q;
    if (tag2_q.valid && (|resp_perr) && (perr_count_q != 16'hFFFF)) begin
      perr_count_d = perr_count_q + 16'd1;
    end
  end

  assign perr_count = perr_count_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Randomised scoreboard bench for bram_arbiter with three requesters and a
// behavioural BRAM that can corrupt parity bits on selected reads.
module tb_bram_arbiter;

  localparam int N   = 3;
  localparam int AW  = 11;
  localparam int RW  = 18;
  localparam int WW  = 36;
  localparam int WEW = 4;

  typedef struct {
    int          due;
    int          id;
    logic [15:0] data;
    logic [1:0]  perr;
  } expResp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*32-1:0] req_wdata;
  logic [N-1:0]    resp_valid;
  logic [15:0]     resp_data;
  logic [1:0]      resp_perr;
  logic [15:0]     perr_count;
  logic [AW-1:0]   bram_addr;
  logic [WW-1:0]   bram_in;
  logic [WEW-1:0]  bram_we;
  logic            bram_valid;
  logic [RW-1:0]   bram_out = '0;

  logic [35:0] bramMem [2048] = '{default: '0};
  logic [31:0] goldMem [2048] = '{default: '0};

  logic          pendValid [N];
  logic          pendWe    [N];
  logic [AW-1:0] pendAddr  [N];
  logic [31:0]   pendData  [N];

  expResp_t   expQ [$];
  logic [1:0] flipQ [$];

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int errCnt     = 0;
  int modelPtr   = 0;
  int injectPct  = 0;
  logic monOn    = 1'b0;

  logic          issRst  = 1'b1;
  logic          issHs   = 1'b0;
  logic          issWe   = 1'b0;
  logic [AW-1:0] issAddr = '0;
  logic [WW-1:0] issIn   = '0;

  bram_arbiter #(
    .N_REQ      (N),
    .ADDR_WIDTH (AW),
    .READ_WIDTH (RW),
    .WRITE_WIDTH(WW),
    .WE_WIDTH   (WEW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .resp_perr (resp_perr),
    .perr_count(perr_count),
    .bram_addr (bram_addr),
    .bram_in   (bram_in),
    .bram_we   (bram_we),
    .bram_valid(bram_valid),
    .bram_out  (bram_out)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // BRAM stand-in: writes land at the edge, reads return a cycle later with
  // the parity bits optionally flipped as chosen when the read was granted.
  initial begin : bramModel
    logic [1:0] f;
    forever begin
      @(posedge clk);
      if (bram_valid === 1'b1) begin
        if (bram_we != '0) begin
          bramMem[bram_addr] <= bram_in;
        end else begin
          f = (flipQ.size() > 0) ? flipQ.pop_front() : 2'b00;
          bram_out <= bramMem[bram_addr][17:0] ^ {f[1], 8'h00, f[0], 8'h00};
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared = compared + 1;
    if (actual !== expected) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic [35:0] expWord(input logic [31:0] d);
    logic [35:0] w;
    logic [7:0]  by;
    w = '0;
    for (int b = 0; b < 4; b++) begin
      by = d[8*b +: 8];
      w[9*b +: 9] = {^by, by};
    end
    return w;
  endfunction

  task automatic setRequest(input int i, input logic we, input logic [AW-1:0] addr, input logic [31:0] data);
    pendValid[i] = 1'b1;
    pendWe[i]    = we;
    pendAddr[i]  = addr;
    pendData[i]  = data;
  endtask

  task automatic genRequests(input logic [N-1:0] active, input int newPct, input int wrPct, input int addrMax);
    for (int i = 0; i < N; i++) begin
      if (active[i] && !pendValid[i] && ($urandom_range(99) < newPct)) begin
        setRequest(i, ($urandom_range(99) < wrPct), AW'($urandom_range(addrMax)), $urandom);
      end
    end
  endtask

  // One clock: drive pending requests, predict the grant, record what the
  // issue port and the response queue must show afterwards.
  task automatic applyStimulus(input logic rstN);
    int         g;
    int         idx;
    logic [N-1:0] expReady;
    logic [1:0] flip;
    expResp_t   e;
    @(negedge clk);
    reset = rstN;
    for (int i = 0; i < N; i++) begin
      req_valid[i]            = pendValid[i];
      req_we[i]               = pendWe[i];
      req_addr[i*AW +: AW]    = pendAddr[i];
      req_wdata[i*32 +: 32]   = pendData[i];
    end
    #4;
    g = -1;
    if (rstN) begin
      for (int k = 0; k < N; k++) begin
        idx = (modelPtr + k) % N;
        if (g < 0 && pendValid[idx]) g = idx;
      end
    end
    expReady = '0;
    if (g >= 0) expReady[g] = 1'b1;
    checkOutput("req_ready", 64'(req_ready), 64'(expReady));
    issRst = !rstN;
    issHs  = 1'b0;
    if (!rstN) begin
      while (expQ.size() > 0 && expQ[expQ.size()-1].due > cyc) begin
        void'(expQ.pop_back());
      end
      errCnt   = 0;
      modelPtr = 0;
    end else if (g >= 0) begin
      issHs   = 1'b1;
      issAddr = pendAddr[g];
      issWe   = pendWe[g];
      if (pendWe[g]) begin
        issIn = expWord(pendData[g]);
        goldMem[pendAddr[g]] = pendData[g];
      end else begin
        issIn = '0;
        flip  = ($urandom_range(99) < injectPct) ? 2'($urandom_range(3, 1)) : 2'b00;
        flipQ.push_back(flip);
        e.due  = cyc + 2;
        e.id   = g;
        e.data = goldMem[pendAddr[g]][15:0];
        e.perr = flip;
        expQ.push_back(e);
      end
      pendValid[g] = 1'b0;
      modelPtr     = (g + 1) % N;
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1);
  endtask

  // Monitor: checks the issue port and counter every cycle and pops the
  // scoreboard whenever a response is presented.
  initial begin : monitor
    expResp_t m;
    forever begin
      @(negedge clk);
      if (monOn) begin
        checkOutput("perr_count", 64'(perr_count), 64'(errCnt));
        if (issRst) begin
          checkOutput("rst_bram_valid", 64'(bram_valid), 64'(0));
          checkOutput("rst_bram_we", 64'(bram_we), 64'(0));
          checkOutput("rst_bram_addr", 64'(bram_addr), 64'(0));
          checkOutput("rst_bram_in", 64'(bram_in), 64'(0));
        end else begin
          checkOutput("bram_valid", 64'(bram_valid), 64'(issHs));
          if (issHs) begin
            checkOutput("bram_addr", 64'(bram_addr), 64'(issAddr));
            checkOutput("bram_we", 64'(bram_we), issWe ? 64'hF : 64'h0);
            checkOutput("bram_in", 64'(bram_in), 64'(issIn));
          end else begin
            checkOutput("bram_we_idle", 64'(bram_we), 64'(0));
          end
        end
        if (resp_valid != '0) begin
          if (expQ.size() == 0) begin
            compared   = compared + 1;
            mismatched = mismatched + 1;
            $display("[TB] FAIL unexpected_resp: got resp_valid %0h expected none (cycle %0d)", resp_valid, cyc);
          end else begin
            m = expQ.pop_front();
            checkOutput("resp_valid", 64'(resp_valid), 64'(1) << m.id);
            checkOutput("resp_cycle", 64'(cyc), 64'(m.due));
            checkOutput("resp_data", 64'(resp_data), 64'(m.data));
            checkOutput("resp_perr", 64'(resp_perr), 64'(m.perr));
            if (m.perr != 2'b00 && errCnt < 65535) errCnt = errCnt + 1;
          end
        end else if (expQ.size() > 0 && expQ[0].due <= cyc) begin
          m = expQ.pop_front();
          compared   = compared + 1;
          mismatched = mismatched + 1;
          $display("[TB] FAIL missing_resp: got no resp_valid expected id %0d due %0d (cycle %0d)", m.id, m.due, cyc);
        end
      end
    end
  end

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < N; i++) setRequest(i, 1'b0, AW'(i), 32'h0);

    $display("[TB] reset with all requesters valid");
    applyStimulus(1'b0);
    monOn = 1'b1;
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    checkOutput("rst_resp_valid", 64'(resp_valid), 64'(0));
    checkOutput("rst_perr_count", 64'(perr_count), 64'(0));

    $display("[TB] round-robin with all three valid");
    for (int c = 0; c < 9; c++) begin
      genRequests(3'b111, 100, 0, 31);
      applyStimulus(1'b1);
    end
    idleCycles(5);

    $display("[TB] write then read-back on requester 0");
    setRequest(0, 1'b1, 11'h005, 32'hA1B2C3D4);
    applyStimulus(1'b1);
    setRequest(0, 1'b0, 11'h005, 32'h0);
    applyStimulus(1'b1);
    injectPct = 100;
    setRequest(1, 1'b0, 11'h005, 32'h0);
    applyStimulus(1'b1);
    injectPct = 0;
    idleCycles(4);

    $display("[TB] random traffic");
    injectPct = 15;
    for (int c = 0; c < 600; c++) begin
      genRequests(3'b111, 60, 35, 15);
      applyStimulus(1'b1);
    end
    idleCycles(4);

    $display("[TB] single requester, error counter saturation");
    injectPct = 100;
    for (int c = 0; c < 65540; c++) begin
      genRequests(3'b001, 100, 0, 15);
      applyStimulus(1'b1);
    end
    injectPct = 0;
    idleCycles(4);
    checkOutput("perr_saturated", 64'(perr_count), 64'hFFFF);

    $display("[TB] reset with a read in flight");
    setRequest(0, 1'b0, 11'h005, 32'h0);
    applyStimulus(1'b1);
    for (int i = 0; i < N; i++) setRequest(i, 1'b0, AW'(i + 8), 32'h0);
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    checkOutput("post_reset_grant0", 64'(issHs && pendValid[0] == 1'b0), 64'(1));

    for (int c = 0; c < 10 && expQ.size() > 0; c++) applyStimulus(1'b1);
    idleCycles(3);
    if (expQ.size() > 0) begin
      compared   = compared + 1;
      mismatched = mismatched + 1;
      $display("[TB] FAIL drain: got %0d responses outstanding expected 0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
